// File: rtl/pixel_stream_ctrl.sv
// pixel_stream_ctrl: frame controller steering pixels through external gray/sobel engines,
// tracking engine latencies, draining after finish and flagging mid-frame mode/start activity.
module pixel_stream_ctrl #(
    parameter int PIXEL_W_IN   = 24,
    parameter int PIXEL_W_GRAY = 8,
    parameter int GRAY_LAT     = 2,
    parameter int DRAIN_CYCLES = 16,
    parameter int CNT_W        = 20
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic [1:0]              select_i,
    input  logic                    start_i,
    input  logic                    finish_i,
    input  logic                    in_valid_i,
    input  logic [PIXEL_W_IN-1:0]   in_pixel_i,
    output logic                    in_ready_o,
    output logic                    gray_start_o,
    output logic [PIXEL_W_IN-1:0]   gray_px_o,
    input  logic [PIXEL_W_GRAY-1:0] gray_px_i,
    output logic                    sobel_start_o,
    output logic                    sobel_valid_o,
    output logic [PIXEL_W_GRAY-1:0] sobel_px_o,
    input  logic [PIXEL_W_GRAY-1:0] sobel_px_i,
    input  logic                    sobel_ready_i,
    output logic                    eng_finish_o,
    output logic                    out_valid_o,
    output logic [PIXEL_W_IN-1:0]   out_pixel_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [CNT_W-1:0]        in_count_o,
    output logic [CNT_W-1:0]        out_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DW = $clog2(DRAIN_CYCLES) + 1;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [GRAY_LAT-1:0]     gv_q, gv_d;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic                    gray_start_q, gray_start_d, sobel_start_q, sobel_start_d;
    logic                    eng_finish_q, eng_finish_d, out_valid_q, out_valid_d;
    logic                    done_q, done_d, err_q, err_d;
    logic [PIXEL_W_IN-1:0]   out_pixel_q, out_pixel_d;
    logic [CNT_W-1:0]        in_count_q, in_count_d, out_count_q, out_count_d;
    logic                    acc, tail, sobel_mode, go, drain_exit;

    assign in_ready_o = state_q == RUN;
    assign acc        = in_valid_i & in_ready_o;
    assign tail       = gv_q[GRAY_LAT-1];
    assign sobel_mode = mode_q[0] ^ mode_q[1];
    assign go         = state_q == IDLE && start_i;
    // Sobel latency is unknown to us, so sobel modes drain for a fixed window
    assign drain_exit = sobel_mode ? dcnt_q == DW'(DRAIN_CYCLES - 1) : gv_q == '0;

    assign gray_px_o     = in_ready_o ? in_pixel_i : '0;
    assign sobel_px_o    = mode_q == 2'b01 ? (in_ready_o ? in_pixel_i[PIXEL_W_GRAY-1:0] : '0)
                         : mode_q == 2'b10 ? gray_px_i : '0;
    assign sobel_valid_o = mode_q == 2'b01 ? acc : mode_q == 2'b10 && tail;

    always_comb begin
        state_d       = go ? RUN
                      : state_q == RUN && finish_i ? DRAIN
                      : state_q == DRAIN && drain_exit ? IDLE : state_q;
        mode_d        = go ? select_i : mode_q;
        gv_d          = (gv_q << 1) | GRAY_LAT'(acc & ~mode_q[0]);
        dcnt_d        = state_q == DRAIN ? dcnt_q + DW'(1) : '0;
        gray_start_d  = go & ~select_i[0];
        sobel_start_d = go & (select_i[0] ^ select_i[1]);
        eng_finish_d  = state_q == RUN && finish_i;
        out_valid_d   = mode_q == 2'b11 ? acc
                      : sobel_mode ? sobel_ready_i && state_q != IDLE
                      : mode_q == 2'b00 && tail;
        out_pixel_d   = !out_valid_d ? out_pixel_q
                      : mode_q == 2'b11 ? in_pixel_i
                      : sobel_mode ? PIXEL_W_IN'(sobel_px_i) : PIXEL_W_IN'(gray_px_i);
        done_d        = state_q == DRAIN && drain_exit;
        err_d         = go ? 1'b0 : err_q | (state_q != IDLE && (start_i || select_i != mode_q));
        in_count_d    = go ? '0 : in_count_q + CNT_W'(acc);
        out_count_d   = go ? '0 : out_count_q + CNT_W'(out_valid_d);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= IDLE;
            mode_q        <= '0;
            gv_q          <= '0;
            dcnt_q        <= '0;
            gray_start_q  <= 1'b0;
            sobel_start_q <= 1'b0;
            eng_finish_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_pixel_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            in_count_q    <= '0;
            out_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            gv_q          <= gv_d;
            dcnt_q        <= dcnt_d;
            gray_start_q  <= gray_start_d;
            sobel_start_q <= sobel_start_d;
            eng_finish_q  <= eng_finish_d;
            out_valid_q   <= out_valid_d;
            out_pixel_q   <= out_pixel_d;
            done_q        <= done_d;
            err_q         <= err_d;
            in_count_q    <= in_count_d;
            out_count_q   <= out_count_d;
        end
    end

    assign gray_start_o  = gray_start_q;
    assign sobel_start_o = sobel_start_q;
    assign eng_finish_o  = eng_finish_q;
    assign out_valid_o   = out_valid_q;
    assign out_pixel_o   = out_pixel_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign in_count_o    = in_count_q;
    assign out_count_o   = out_count_q;
endmodule
